des_key_rotator: RTL and testbench

Sequential, parametrised key-schedule rotator for the DES datapath. It accepts a C0/D0 key-half pair on a start handshake and produces the rotated Ci/Di pair for every round, one round per accepted output beat. Rotation is left for encryption and right for decryption. Per-round shift amounts (1 or 2) come from a parameter bitmap. It sits between PC-1 and PC-2 and replaces per-round combinational rotation driven by an external round counter.

---
 rtl/des_key_rotator.sv | 159 +++++++++++++++
 tb/tb_des_key_rotator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_rotator.sv
// DES key-schedule rotator: turns a C0/D0 pair into per-round Ci/Di, one round per accepted beat.
// Optional feature macro DES_ROTATOR_DIR_EN enables decrypt (right-rotate) schedules.
module des_key_rotator #(
  parameter int HALF_W = 28,
  parameter int ROUNDS = 16,
  parameter int RND_W  = 4,
  parameter logic [ROUNDS-1:0] SHIFT_MAP = 16'h8103
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              decrypt,
  input  logic [HALF_W-1:0] c0_in,
  input  logic [HALF_W-1:0] d0_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RND_W-1:0]  round_idx,
  output logic [HALF_W-1:0] ci_out,
  output logic [HALF_W-1:0] di_out,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);

  state_t state, state_nxt;

  logic [RND_W-1:0]  nxt_idx;
  logic              enc_one;
  logic [HALF_W-1:0] first_c, first_d;
  logic [HALF_W-1:0] step_c, step_d;

  function automatic logic [HALF_W-1:0] rot_left(input logic [HALF_W-1:0] x, input logic one);
    return one ? {x[HALF_W-2:0], x[HALF_W-1]} : {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
  endfunction

`ifdef DES_ROTATOR_DIR_EN
  // Decrypt round r>1 undoes encrypt round ROUNDS+2-r, so its map is the encrypt map read backwards.
  function automatic logic [ROUNDS-1:0] reverse_map(input logic [ROUNDS-1:0] m);
    logic [ROUNDS-1:0] r;
    for (int k = 0; k < ROUNDS; k++) r[k] = m[(ROUNDS - k) % ROUNDS];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rot_right(input logic [HALF_W-1:0] x, input logic one);
    return one ? {x[0], x[HALF_W-1:1]} : {x[1:0], x[HALF_W-1:2]};
  endfunction

  localparam logic [ROUNDS-1:0] DEC_MAP = reverse_map(SHIFT_MAP);

  logic dir;
  logic dec_one;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
`endif

  assign nxt_idx = round_idx + RND_W'(1);

  always_comb begin
    enc_one = 1'b0;
`ifdef DES_ROTATOR_DIR_EN
    dec_one = 1'b0;
`endif
    for (int k = 0; k < ROUNDS; k++) begin
      if (nxt_idx == RND_W'(k)) begin
        enc_one = SHIFT_MAP[k];
`ifdef DES_ROTATOR_DIR_EN
        dec_one = DEC_MAP[k];
`endif
      end
    end
  end

  always_comb begin
    first_c = rot_left(c0_in, SHIFT_MAP[0]);
    first_d = rot_left(d0_in, SHIFT_MAP[0]);
    step_c  = rot_left(ci_out, enc_one);
    step_d  = rot_left(di_out, enc_one);
`ifdef DES_ROTATOR_DIR_EN
    if (decrypt) begin
      first_c = c0_in;
      first_d = d0_in;
    end
    if (dir) begin
      step_c = rot_right(ci_out, dec_one);
      step_d = rot_right(di_out, dec_one);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (out_ready && round_idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The held pair only moves on an accepted beat, so back-pressure freezes the outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      round_idx <= '0;
      ci_out    <= '0;
      di_out    <= '0;
`ifdef DES_ROTATOR_DIR_EN
      dir       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            round_idx <= '0;
            ci_out    <= first_c;
            di_out    <= first_d;
`ifdef DES_ROTATOR_DIR_EN
            dir       <= decrypt;
`endif
          end
        end
        RUN: begin
          if (out_ready && round_idx != LAST_IDX) begin
            round_idx <= nxt_idx;
            ci_out    <= step_c;
            di_out    <= step_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_rotator.sv
// Self-checking bench for des_key_rotator: vector table, hand-written corner sequences and
// randomized schedules compared against a cumulative-rotation reference model.
module tb_des_key_rotator;

  localparam int HALF_W = 28;
  localparam int ROUNDS = 16;
  localparam logic [15:0] MAP = 16'h8103;
`ifdef DES_ROTATOR_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        decrypt;
  logic [27:0] c0_in, d0_in;
  logic        busy, out_valid, out_ready, done;
  logic [3:0]  round_idx;
  logic [27:0] ci_out, di_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [27:0] got_c [ROUNDS];
  logic [27:0] got_d [ROUNDS];

  des_key_rotator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .decrypt(decrypt),
    .c0_in(c0_in), .d0_in(d0_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .round_idx(round_idx), .ci_out(ci_out),
    .di_out(di_out), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int shift_of(input int r);
    return MAP[r-1] ? 1 : 2;
  endfunction

  // Round i (0-based) is the start value rotated by the running total of all shifts so far.
  function automatic logic [27:0] model_round(input logic [27:0] x, input int i, input logic dec);
    logic [55:0] w;
    int amt = 0;
    if (dec && DIR_EN) begin
      for (int r = 2; r <= i + 1; r++) amt += shift_of(ROUNDS + 2 - r);
      w = {x, x} >> (amt % HALF_W);
      return w[27:0];
    end
    for (int r = 1; r <= i + 1; r++) amt += shift_of(r);
    w = {x, x} << (amt % HALF_W);
    return w[55:28];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [27:0] c0, input logic [27:0] d0, input logic dec,
                               input int stall_at, input int stall_len, input int inject_at);
    int cyc = 1;
    int beat = 0;
    int stall_cnt = 0;
    bit stalling = 0, stalled = 0, injected = 0, timed_out = 0;
    logic [27:0] frz_c, frz_d;
    logic [3:0]  frz_idx;
    c0_in = c0; d0_in = d0; decrypt = dec; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_busy", 32'(busy), 32'd1);
    while (!done) begin
      if (cyc > 200) begin
        timed_out = 1;
        break;
      end
      if (injected && start) start = 1'b0;
      if (out_valid) begin
        if (stalling) begin
          checkOutput("stall_idx", 32'(round_idx), 32'(frz_idx));
          checkOutput("stall_ci", 32'(ci_out), 32'(frz_c));
          checkOutput("stall_di", 32'(di_out), 32'(frz_d));
          stall_cnt++;
          if (stall_cnt == stall_len) begin
            stalling = 0;
            out_ready = 1'b1;
          end
        end else if (stall_len > 0 && !stalled && int'(round_idx) == stall_at) begin
          stalling = 1; stalled = 1;
          frz_c = ci_out; frz_d = di_out; frz_idx = round_idx;
          out_ready = 1'b0;
        end
        if (inject_at >= 0 && !injected && int'(round_idx) == inject_at) begin
          start = 1'b1; c0_in = ~c0; d0_in = ~d0; decrypt = ~dec;
          injected = 1;
          checkOutput("busy_at_inject", 32'(busy), 32'd1);
        end
        if (out_ready && beat < ROUNDS) begin
          checkOutput("round_seq", 32'(round_idx), 32'(beat));
          checkOutput("ci_model", 32'(ci_out), 32'(model_round(c0, beat, dec)));
          checkOutput("di_model", 32'(di_out), 32'(model_round(d0, beat, dec)));
          got_c[beat] = ci_out;
          got_d[beat] = di_out;
          beat++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (timed_out) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL schedule_timeout: got no done after %0d cycles, expected done", cyc);
    end else begin
      checkOutput("done_cycle", 32'(cyc), 32'(ROUNDS + 1 + (stalled ? stall_len : 0)));
      checkOutput("beats", 32'(beat), 32'(ROUNDS));
      checkOutput("valid_at_done", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("done_width", 32'(done), 32'd0);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  typedef struct {
    string       name;
    logic [27:0] c0;
    logic [27:0] d0;
    logic        dec;
    int          rnd;
    logic [27:0] exp_c;
    logic [27:0] exp_d;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int sum = 0;
    int waited;
    reset_n = 1'b0; start = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
    c0_in = '0; d0_in = '0;

    for (int r = 1; r <= ROUNDS; r++) sum += shift_of(r);
    if (sum != HALF_W) begin
      $display("[TB] FAIL shift_sum: got %0d, expected %0d", sum, HALF_W);
      $fatal(1, "[TB] shift map does not sum to a full rotation");
    end

    vecs[0] = '{"enc_r0",  28'h0000001, 28'h8000000, 1'b0, 0,  28'h0000002, 28'h0000001};
    vecs[1] = '{"enc_r2",  28'h0000001, 28'h8000000, 1'b0, 2,  28'h0000010, 28'h0000008};
    vecs[2] = '{"enc_r15", 28'h0000001, 28'h8000000, 1'b0, 15, 28'h0000001, 28'h8000000};
    if (DIR_EN) begin
      vecs[3] = '{"dec_r0",  28'h0000001, 28'h8000000, 1'b1, 0,  28'h0000001, 28'h8000000};
      vecs[4] = '{"dec_r1",  28'h0000001, 28'h8000000, 1'b1, 1,  28'h8000000, 28'h4000000};
      vecs[5] = '{"dec_r2",  28'h0000001, 28'h8000000, 1'b1, 2,  28'h2000000, 28'h1000000};
      vecs[6] = '{"dec_r15", 28'h0000001, 28'h8000000, 1'b1, 15, 28'h0000002, 28'h0000001};
    end else begin
      vecs[3] = '{"nodir_r0",  28'h0000001, 28'h8000000, 1'b1, 0,  28'h0000002, 28'h0000001};
      vecs[4] = '{"nodir_r1",  28'h0000001, 28'h8000000, 1'b1, 1,  28'h0000004, 28'h0000002};
      vecs[5] = '{"nodir_r2",  28'h0000001, 28'h8000000, 1'b1, 2,  28'h0000010, 28'h0000008};
      vecs[6] = '{"nodir_r15", 28'h0000001, 28'h8000000, 1'b1, 15, 28'h0000001, 28'h8000000};
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_idx", 32'(round_idx), 32'd0);
    checkOutput("rst_ci", 32'(ci_out), 32'd0);
    checkOutput("rst_di", 32'(di_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].c0, vecs[v].d0, vecs[v].dec, -1, 0, -1);
      checkOutput({vecs[v].name, "_ci"}, 32'(got_c[vecs[v].rnd]), 32'(vecs[v].exp_c));
      checkOutput({vecs[v].name, "_di"}, 32'(got_d[vecs[v].rnd]), 32'(vecs[v].exp_d));
    end

    $display("[TB] back-pressure at round 5 and ignored start at round 7");
    applyStimulus(28'h0000001, 28'h8000000, 1'b0, 5, 3, -1);
    applyStimulus(28'h0123456, 28'h0ABCDEF, 1'b1, -1, 0, 7);

    $display("[TB] reset mid-schedule at round 9");
    c0_in = 28'h5A5A5A5; d0_in = 28'h3C3C3C3; decrypt = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (round_idx != 4'd9 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reached_round9", 32'(round_idx), 32'd9);
    reset_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_idx", 32'(round_idx), 32'd0);
    checkOutput("midrst_ci", 32'(ci_out), 32'd0);
    checkOutput("midrst_di", 32'(di_out), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_done", 32'(done), 32'd0);
      checkOutput("midrst_idle", 32'(busy), 32'd0);
    end
    applyStimulus(28'h5A5A5A5, 28'h3C3C3C3, 1'b0, -1, 0, -1);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(28'($urandom), 28'($urandom), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
